// File: rtl/histogram_accum_if.sv
// histogram_accum_if: pixel stream, frame control, readout and status signals of histogram_accum
// Ports: i_pixel_in/i_valid/i_last pixel stream, i_clear new-frame request, i_rd_en/i_rd_addr readout request,
// o_rd_data/o_rd_valid readout result, o_ready accepting pixels, o_done histogram frozen, o_sat sticky saturation.
interface histogram_accum_if #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 16
) ();
  logic [PIX_W-1:0] i_pixel_in;
  logic             i_valid;
  logic             i_last;
  logic             i_clear;
  logic             i_rd_en;
  logic [PIX_W-1:0] i_rd_addr;
  logic [CNT_W-1:0] o_rd_data;
  logic             o_rd_valid;
  logic             o_ready;
  logic             o_done;
  logic             o_sat;
  modport slave (
    input  i_pixel_in, i_valid, i_last, i_clear, i_rd_en, i_rd_addr,
    output o_rd_data, o_rd_valid, o_ready, o_done, o_sat
  );
  modport master (
    output i_pixel_in, i_valid, i_last, i_clear, i_rd_en, i_rd_addr,
    input  o_rd_data, o_rd_valid, o_ready, o_done, o_sat
  );
endinterface

// File: rtl/histogram_accum.sv
// histogram_accum: per-frame luma histogram with forwarding read-modify-write pipeline, saturating bins, clear sweep and frozen readout
// Ports: clk, reset (synchronous, active-high); bus (slave) carries the pixel stream, clear request, readout port and status flags.
module histogram_accum #(
  parameter int PIX_W = 8,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               reset,
  histogram_accum_if.slave  bus
);
  localparam int N = 1 << PIX_W;
  localparam logic [CNT_W-1:0] MAX = '1;
  typedef enum logic [1:0] {S_CLEAR, S_ACCUM, S_DRAIN, S_HOLD} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_mem [N];
  logic [PIX_W-1:0] r_sweep, r_p1_addr, r_p2_addr;
  logic             r_p1_v, r_p2_v, r_drain;
  logic [CNT_W-1:0] r_p1_cnt, r_p2_cnt, r_rd_data;
  logic             r_rd_valid, r_ready, r_done, r_sat;
  logic [CNT_W:0]   w_sum;
  logic             w_ovf, w_accept, w_abort;
  logic [CNT_W-1:0] w_inc, w_rd_cnt;
  assign w_sum    = {1'b0, r_p1_cnt} + (CNT_W+1)'(1);
  assign w_ovf    = w_sum[CNT_W];
  assign w_inc    = w_ovf ? MAX : w_sum[CNT_W-1:0];
  assign w_accept = r_state == S_ACCUM && bus.i_valid && !bus.i_clear;
  assign w_abort  = r_state == S_ACCUM && bus.i_clear;
  // Newest in-flight update to the same bin wins: stage 1 result beats the stage 2 write, which beats memory.
  assign w_rd_cnt = (r_p1_v && r_p1_addr == bus.i_pixel_in) ? w_inc :
                    (r_p2_v && r_p2_addr == bus.i_pixel_in) ? r_p2_cnt : r_mem[bus.i_pixel_in];
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) r_mem[r_sweep] <= '0;
    else if (r_p2_v) r_mem[r_p2_addr] <= r_p2_cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_CLEAR;
      r_sweep    <= '0;
      r_p1_v     <= 1'b0;
      r_p2_v     <= 1'b0;
      r_drain    <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      r_p1_v     <= w_accept;
      r_p1_addr  <= bus.i_pixel_in;
      r_p1_cnt   <= w_rd_cnt;
      r_p2_v     <= r_p1_v && !w_abort;
      r_p2_addr  <= r_p1_addr;
      r_p2_cnt   <= w_inc;
      r_rd_valid <= r_state == S_HOLD && bus.i_rd_en;
      if (r_state == S_HOLD && bus.i_rd_en) r_rd_data <= r_mem[bus.i_rd_addr];
      if (r_p1_v && w_ovf) r_sat <= 1'b1;
      case (r_state)
        S_CLEAR: begin
          r_sweep <= r_sweep + 1'b1;
          r_sat   <= 1'b0;
          if (r_sweep == '1) begin
            r_state <= S_ACCUM;
            r_ready <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (bus.i_clear) begin
            r_state <= S_CLEAR;
            r_sweep <= '0;
            r_ready <= 1'b0;
            r_sat   <= 1'b0;
          end else if (bus.i_valid && bus.i_last) begin
            r_state <= S_DRAIN;
            r_ready <= 1'b0;
            r_drain <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_drain <= 1'b1;
          if (r_drain) begin
            r_state <= S_HOLD;
            r_done  <= 1'b1;
          end
        end
        default: begin
          if (bus.i_clear) begin
            r_state <= S_CLEAR;
            r_sweep <= '0;
            r_done  <= 1'b0;
            r_sat   <= 1'b0;
          end
        end
      endcase
    end
  end
  assign bus.o_rd_data  = r_rd_data;
  assign bus.o_rd_valid = r_rd_valid;
  assign bus.o_ready    = r_ready;
  assign bus.o_done     = r_done;
  assign bus.o_sat      = r_sat;
endmodule

// File: tb/tb_histogram_accum.sv
// tb_histogram_accum: directed bench driving a 16-bit and a 4-bit counter instance with identical pixel streams
module tb_histogram_accum;
  localparam int N = 256;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  histogram_accum_if #(.PIX_W(8), .CNT_W(16)) ifa ();
  histogram_accum_if #(.PIX_W(8), .CNT_W(4))  ifb ();
  histogram_accum #(.PIX_W(8), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  histogram_accum #(.PIX_W(8), .CNT_W(4))  dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
  assign ifb.i_pixel_in = ifa.i_pixel_in;
  assign ifb.i_valid    = ifa.i_valid;
  assign ifb.i_last     = ifa.i_last;
  assign ifb.i_clear    = ifa.i_clear;
  assign ifb.i_rd_en    = ifa.i_rd_en;
  assign ifb.i_rd_addr  = ifa.i_rd_addr;
  typedef struct {
    int         len;
    logic [7:0] pix [20];
    int         b0, e0a, e0b, b1, e1a, e1b;
    bit         sat_a, sat_b;
  } vec_t;
  vec_t       vecs [4];
  logic [7:0] cur [128];
  int         ma [N], mb [N], ga [N], gb [N];
  bit         msa, msb;
  int         checks = 0;
  int         errors = 0;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      ma[i] = 0;
      mb[i] = 0;
    end
    msa = 0;
    msb = 0;
  endtask
  task automatic model_add(input int p);
    if (ma[p] == 65535) msa = 1; else ma[p]++;
    if (mb[p] == 15) msb = 1; else mb[p]++;
  endtask
  task automatic wait_ready();
    for (int i = 1; i <= N; i++) begin
      tick();
      if (i == N - 1) begin
        check("ready_low_before_sweep_end_a", ifa.o_ready, 0);
        check("ready_low_before_sweep_end_b", ifb.o_ready, 0);
      end
    end
    check("ready_after_sweep_a", ifa.o_ready, 1);
    check("ready_after_sweep_b", ifb.o_ready, 1);
  endtask
  task automatic send_frame(input int len);
    check("ready_at_frame_start", ifa.o_ready, 1);
    for (int i = 0; i < len; i++) begin
      ifa.i_valid    = 1'b1;
      ifa.i_pixel_in = cur[i];
      ifa.i_last     = (i == len - 1);
      model_add(int'(cur[i]));
      tick();
    end
    ifa.i_valid = 1'b0;
    ifa.i_last  = 1'b0;
    check("ready_drop_after_last", ifa.o_ready, 0);
    check("done_low_after_last", ifa.o_done, 0);
  endtask
  task automatic finish_frame();
    tick();
    check("done_low_drain2", ifa.o_done, 0);
    tick();
    check("done_high_a", ifa.o_done, 1);
    check("done_high_b", ifb.o_done, 1);
    ifa.i_valid = 1'b0;
    ifa.i_clear = 1'b0;
  endtask
  task automatic read_all();
    ifa.i_rd_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      ifa.i_rd_addr = 8'(i);
      tick();
      check("rd_valid", ifa.o_rd_valid, 1);
      check($sformatf("bin_a[%0d]", i), ifa.o_rd_data, ma[i]);
      check($sformatf("bin_b[%0d]", i), ifb.o_rd_data, mb[i]);
      ga[i] = int'(ifa.o_rd_data);
      gb[i] = int'(ifb.o_rd_data);
    end
    ifa.i_rd_en = 1'b0;
    check("sat_a_model", ifa.o_sat, msa);
    check("sat_b_model", ifb.o_sat, msb);
  endtask
  task automatic clear_frame(input int addr);
    ifa.i_rd_en   = 1'b1;
    ifa.i_rd_addr = 8'(addr);
    ifa.i_clear   = 1'b1;
    tick();
    ifa.i_rd_en = 1'b0;
    ifa.i_clear = 1'b0;
    check("read_with_clear_valid", ifa.o_rd_valid, 1);
    check("read_with_clear_data", ifa.o_rd_data, ma[addr]);
    check("sat_b_cleared", ifb.o_sat, 0);
    check("done_drop_on_clear", ifa.o_done, 0);
    model_reset();
    wait_ready();
  endtask
  task automatic check_reset_values();
    check("rst_ready", ifa.o_ready, 0);
    check("rst_done", ifa.o_done, 0);
    check("rst_sat_a", ifa.o_sat, 0);
    check("rst_sat_b", ifb.o_sat, 0);
    check("rst_rd_valid", ifa.o_rd_valid, 0);
    check("rst_rd_data_a", ifa.o_rd_data, 0);
    check("rst_rd_data_b", ifb.o_rd_data, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0].len = 1;  vecs[0].pix[0] = 8'd0;
    vecs[0].b0 = 0; vecs[0].e0a = 1; vecs[0].e0b = 1; vecs[0].b1 = 1; vecs[0].e1a = 0; vecs[0].e1b = 0;
    vecs[0].sat_a = 0; vecs[0].sat_b = 0;
    vecs[1].len = 5;
    for (int i = 0; i < 4; i++) vecs[1].pix[i] = 8'd5;
    vecs[1].pix[4] = 8'd9;
    vecs[1].b0 = 5; vecs[1].e0a = 4; vecs[1].e0b = 4; vecs[1].b1 = 9; vecs[1].e1a = 1; vecs[1].e1b = 1;
    vecs[1].sat_a = 0; vecs[1].sat_b = 0;
    vecs[2].len = 5;
    for (int i = 0; i < 5; i++) vecs[2].pix[i] = (i % 2 == 0) ? 8'd3 : 8'd7;
    vecs[2].b0 = 3; vecs[2].e0a = 3; vecs[2].e0b = 3; vecs[2].b1 = 7; vecs[2].e1a = 2; vecs[2].e1b = 2;
    vecs[2].sat_a = 0; vecs[2].sat_b = 0;
    vecs[3].len = 20;
    for (int i = 0; i < 20; i++) vecs[3].pix[i] = 8'd7;
    vecs[3].b0 = 7; vecs[3].e0a = 20; vecs[3].e0b = 15; vecs[3].b1 = 6; vecs[3].e1a = 0; vecs[3].e1b = 0;
    vecs[3].sat_a = 0; vecs[3].sat_b = 1;
    ifa.i_pixel_in = '0;
    ifa.i_valid    = 1'b0;
    ifa.i_last     = 1'b0;
    ifa.i_clear    = 1'b0;
    ifa.i_rd_en    = 1'b0;
    ifa.i_rd_addr  = '0;
    reset = 1'b1;
    tick();
    tick();
    check_reset_values();
    reset = 1'b0;
    model_reset();
    wait_ready();
    ifa.i_rd_en = 1'b1;
    tick();
    ifa.i_rd_en = 1'b0;
    check("rd_ignored_outside_hold", ifa.o_rd_valid, 0);
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < vecs[v].len; i++) cur[i] = vecs[v].pix[i];
      send_frame(vecs[v].len);
      finish_frame();
      read_all();
      check($sformatf("vec%0d_bin%0d_a", v, vecs[v].b0), ga[vecs[v].b0], vecs[v].e0a);
      check($sformatf("vec%0d_bin%0d_b", v, vecs[v].b0), gb[vecs[v].b0], vecs[v].e0b);
      check($sformatf("vec%0d_bin%0d_a", v, vecs[v].b1), ga[vecs[v].b1], vecs[v].e1a);
      check($sformatf("vec%0d_bin%0d_b", v, vecs[v].b1), gb[vecs[v].b1], vecs[v].e1b);
      check($sformatf("vec%0d_sat_a", v), ifa.o_sat, vecs[v].sat_a);
      check($sformatf("vec%0d_sat_b", v), ifb.o_sat, vecs[v].sat_b);
      clear_frame(vecs[v].b0);
    end
    ifa.i_valid    = 1'b1;
    ifa.i_pixel_in = 8'd2;
    for (int i = 0; i < 10; i++) tick();
    ifa.i_clear = 1'b1;
    tick();
    ifa.i_clear = 1'b0;
    check("abort_ready_drop", ifa.o_ready, 0);
    model_reset();
    wait_ready();
    cur[0] = 8'd1;
    cur[1] = 8'd1;
    send_frame(2);
    ifa.i_valid    = 1'b1;
    ifa.i_pixel_in = 8'd2;
    ifa.i_clear    = 1'b1;
    finish_frame();
    read_all();
    check("abort_bin2", ga[2], 0);
    check("abort_bin1", ga[1], 2);
    clear_frame(1);
    for (int i = 0; i < 100; i++) begin
      ifa.i_valid    = 1'b1;
      ifa.i_pixel_in = 8'(i);
      tick();
    end
    reset = 1'b1;
    tick();
    check_reset_values();
    reset = 1'b0;
    ifa.i_valid = 1'b0;
    model_reset();
    wait_ready();
    cur[0] = 8'd200;
    send_frame(1);
    finish_frame();
    read_all();
    check("post_reset_bin200", ga[200], 1);
    check("post_reset_bin50", ga[50], 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
